// File: rtl/gen_fifo.sv
// First-word-fall-through FIFO with valid/ready on both ends.
// Pointers carry an extra wrap bit so full and empty are told apart without a separate flag.
module gen_fifo #(
   parameter int DW = 64,
   parameter int AW = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          flush,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [DW-1:0] data_push,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [DW-1:0] data_pop,
   output logic [AW:0]   count
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          push_fire;
   logic          pop_fire;
   logic          clear;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Handshake outputs come only from registered pointers, never from push_valid/pop_ready.
   assign push_ready = !full;
   assign pop_valid  = !empty;
   assign count      = wr_ptr - rd_ptr;
   assign data_pop   = mem[rd_ptr[AW-1:0]];

   assign push_fire = push_valid && push_ready;
   assign pop_fire  = pop_valid && pop_ready;
   assign clear     = RST || flush;

   always_ff @(posedge CLK) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is not reset; a word pushed during flush/reset is dropped.
   always_ff @(posedge CLK) begin
      if (push_fire && !clear) begin
         mem[wr_ptr[AW-1:0]] <= data_push;
      end
   end

endmodule

// File: tb/tb_gen_fifo.sv
// Bench for gen_fifo (DW=64, AW=2): vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_gen_fifo;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush;
   logic        push_valid;
   logic        push_ready;
   logic [63:0] data_push;
   logic        pop_valid;
   logic        pop_ready;
   logic [63:0] data_pop;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   gen_fifo #(.DW(64), .AW(2)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .flush      (flush),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .data_push  (data_push),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .data_pop   (data_pop),
      .count      (count)
   );

   typedef struct {
      logic        rst;
      logic        fl;
      logic        pv;
      logic [63:0] d;
      logic        pr;
      logic [2:0]  cnt;
      logic        vld;
      logic        rdy;
      logic [63:0] dout;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are driven at the falling edge; outputs are then sampled one full cycle later.
   task automatic step(input logic r, input logic f, input logic pv, input logic [63:0] d,
                       input logic pr);
      RST        = r;
      flush      = f;
      push_valid = pv;
      data_push  = d;
      pop_ready  = pr;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic check_state(input string name, input logic [2:0] c, input logic v, input logic r);
      check({name, ".count"}, 64'(count), 64'(c));
      check({name, ".pop_valid"}, 64'(pop_valid), 64'(v));
      check({name, ".push_ready"}, 64'(push_ready), 64'(r));
   endtask

   task automatic push(input logic [63:0] d);
      step(1'b0, 1'b0, 1'b1, d, 1'b0);
   endtask

   task automatic pop_expect(input string name, input logic [63:0] d);
      check(name, data_pop, d);
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
   endtask

   logic [63:0] model_q [$];

   initial begin
      RST = 1'b1; flush = 1'b0; push_valid = 1'b0; data_push = '0; pop_ready = 1'b0;

      //             rst   fl    pv    d       pr    cnt vld   rdy   dout
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'h00, 1'b0, 3'd0, 1'b0, 1'b1, 64'h00};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 64'h00, 1'b0, 3'd0, 1'b0, 1'b1, 64'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 3'd0, 1'b0, 1'b1, 64'h00};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 64'h11, 1'b0, 3'd1, 1'b1, 1'b1, 64'h11};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 64'h22, 1'b0, 3'd2, 1'b1, 1'b1, 64'h11};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 64'h33, 1'b0, 3'd3, 1'b1, 1'b1, 64'h11};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'h44, 1'b0, 3'd4, 1'b1, 1'b0, 64'h11};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 64'h55, 1'b0, 3'd4, 1'b1, 1'b0, 64'h11};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 3'd3, 1'b1, 1'b1, 64'h22};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 3'd2, 1'b1, 1'b1, 64'h33};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 3'd1, 1'b1, 1'b1, 64'h44};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 3'd0, 1'b0, 1'b1, 64'h00};

      @(negedge CLK);
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].rst, tbl[i].fl, tbl[i].pv, tbl[i].d, tbl[i].pr);
         check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].rdy);
         if (tbl[i].vld) check($sformatf("vec%0d.data", i), data_pop, tbl[i].dout);
      end

      // Latency: no same-cycle bypass, then concurrent push+pop keeps count.
      push_valid = 1'b1; data_push = 64'hA0; pop_ready = 1'b0;
      #1 check("lat.same_cycle_valid", 64'(pop_valid), 64'd0);
      step(1'b0, 1'b0, 1'b1, 64'hA0, 1'b0);
      check("lat.next_valid", 64'(pop_valid), 64'd1);
      check("lat.data", data_pop, 64'hA0);
      step(1'b0, 1'b0, 1'b1, 64'hA1, 1'b1);
      check_state("conc", 3'd1, 1'b1, 1'b1);
      check("conc.next_data", data_pop, 64'hA1);
      pop_expect("conc.drain", 64'hA1);
      check_state("conc.empty", 3'd0, 1'b0, 1'b1);

      // Full with simultaneous push and pop: pop retires, push is refused.
      for (int i = 0; i < 4; i++) push(64'hB0 + 64'(i));
      check_state("full", 3'd4, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 64'hBB, 1'b1);
      check_state("full.pp", 3'd3, 1'b1, 1'b1);
      pop_expect("full.d1", 64'hB1);
      pop_expect("full.d2", 64'hB2);
      pop_expect("full.d3", 64'hB3);
      check_state("full.drained", 3'd0, 1'b0, 1'b1);

      // Flush drops stored words and the word pushed alongside it.
      for (int i = 0; i < 3; i++) push(64'hC0 + 64'(i));
      check("flush.pre_count", 64'(count), 64'd3);
      step(1'b0, 1'b1, 1'b1, 64'hCC, 1'b0);
      check_state("flush", 3'd0, 1'b0, 1'b1);
      push(64'hD0);
      check("flush.after_count", 64'(count), 64'd1);
      pop_expect("flush.after_data", 64'hD0);

      // Reset together with flush.
      push(64'hE0);
      push(64'hE1);
      check("rst.pre_count", 64'(count), 64'd2);
      step(1'b1, 1'b1, 1'b1, 64'hEE, 1'b1);
      check_state("rst_flush", 3'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      check_state("rst_flush.idle", 3'd0, 1'b0, 1'b1);

      // Randomized run against a queue model; occupancy bias shifts every 200 cycles.
      model_q.delete();
      for (int i = 0; i < 1000; i++) begin
         int pv_pct;
         int pr_pct;
         logic pv, pr, fl;
         logic [63:0] d;
         case ((i / 200) % 3)
            0: begin pv_pct = 80; pr_pct = 30; end
            1: begin pv_pct = 30; pr_pct = 80; end
            default: begin pv_pct = 60; pr_pct = 60; end
         endcase
         pv = ($urandom_range(0, 99) < pv_pct);
         pr = ($urandom_range(0, 99) < pr_pct);
         fl = ($urandom_range(0, 99) == 0);
         d  = {$urandom, $urandom};

         if (count > 3'd4) begin
            errors++;
            $display("FAIL rnd.count_bound: got %0d limit 4 at cycle %0d", count, i);
         end
         check("rnd.count", 64'(count), 64'(model_q.size()));
         check("rnd.pop_valid", 64'(pop_valid), 64'(model_q.size() != 0));
         check("rnd.push_ready", 64'(push_ready), 64'(model_q.size() < 4));
         if (model_q.size() != 0) check("rnd.data", data_pop, model_q[0]);

         if (fl) begin
            model_q.delete();
         end else begin
            int n;
            n = model_q.size();
            if (pr && n > 0) void'(model_q.pop_front());
            if (pv && n < 4) model_q.push_back(d);
         end
         step(1'b0, fl, pv, d, pr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
